// File: rtl/seq_shift_add_multiplier.sv
// Purpose: sequential shift-and-add multiplier, one multiplier bit per clock, optional two's-complement mode.
// Latency: out_valid rises WIDTH cycles after the accept edge; one operation per WIDTH+2 cycles.
// Backpressure: the result is held in DONE until out_ready; in_ready is high only in IDLE.
module seq_shift_add_multiplier #(
    parameter int WIDTH  = 4,
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     mcand_q, mcand_d;    // multiplicand, shifted left each step
    logic [WIDTH-1:0]  mplier_q, mplier_d;  // multiplier, shifted right each step
    logic [PW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;        // result sign in two's-complement mode
    logic [PW-1:0]     prod_q, prod_d;

    // Operand magnitudes: the core only ever multiplies unsigned values.
    // |-2^(W-1)| = 2^(W-1) still fits in WIDTH unsigned bits.
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic              a_neg, b_neg;
    logic [PW-1:0]     partial, acc_sum;

    // Next-state, datapath step and operand capture.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        prod_d   = prod_q;

        a_neg = 1'b0;
        b_neg = 1'b0;
        a_mag = a;
        b_mag = b;
        if (SIGNED != 0) begin
            a_neg = a[WIDTH-1];
            b_neg = b[WIDTH-1];
            if (a_neg) a_mag = '0 - a;
            if (b_neg) b_mag = '0 - b;
        end

        partial = mplier_q[0] ? mcand_q : '0;
        acc_sum = acc_q + partial;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    neg_d    = a_neg ^ b_neg;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // Final step: publish the (sign-corrected) result on the same edge.
                if (cnt_q == LAST_STEP) begin
                    prod_d  = neg_q ? ('0 - acc_sum) : acc_sum;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            prod_q   <= prod_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_BUSY);
    assign out_valid = (state_q == ST_DONE);
    assign prod      = prod_q;

endmodule
